// File: rtl/fanout_fork_ctrl.sv
// rtl/fanout_fork_ctrl.sv - one-entry eager fork from a single producer to NUM_OUT consumers
// Each enabled consumer handshakes independently; upstream is released once all have taken the token.
module fanout_fork_ctrl #(
  parameter int NUM_OUT = 6,
  parameter int DATA_W  = 17,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_OUT-1:0] cfg_en,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic [NUM_OUT-1:0] out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [CNT_W-1:0]   tok_count,
  output logic               busy
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  data_q;
  logic [NUM_OUT-1:0] en_q;
  logic [NUM_OUT-1:0] sent_q;
  logic [CNT_W-1:0]   count_q;

  logic               full;
  logic               done;
  logic               take;
  logic [NUM_OUT-1:0] hs;

  assign full = (state_q == FULL);

  // Outputs below depend only on flops, so consumers never see a path from their own ready.
  assign out_valid = full ? (en_q & ~sent_q) : '0;
  assign out_data  = data_q;
  assign busy      = full;
  assign tok_count = count_q;

  assign hs   = out_valid & out_ready;
  // A port counts as finished if disabled, already served, or handshaking right now.
  assign done = full & (&(~en_q | sent_q | out_ready));

  assign in_ready = ~flush & (~full | done);
  assign take     = in_ready & in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      en_q    <= '0;
      sent_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      sent_q  <= '0;
    end else begin
      if (done) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (take) begin
        sent_q <= '0;
        if (cfg_en != '0) begin
          data_q  <= in_data;
          en_q    <= cfg_en;
          state_q <= FULL;
        end else begin
          // Zero mask: the token is swallowed and nothing is held.
          state_q <= EMPTY;
        end
      end else if (done) begin
        state_q <= EMPTY;
        sent_q  <= '0;
      end else if (full) begin
        sent_q <= sent_q | hs;
      end
    end
  end

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// tb/tb_fanout_fork_ctrl.sv - directed self-checking bench for fanout_fork_ctrl
module tb_fanout_fork_ctrl;

  localparam int NUM_OUT = 6;
  localparam int DATA_W  = 17;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_OUT-1:0] cfg_en = '0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic [DATA_W-1:0]  in_data = '0;
  logic               in_ready;
  logic [NUM_OUT-1:0] out_valid;
  logic [DATA_W-1:0]  out_data;
  logic [NUM_OUT-1:0] out_ready = '0;
  logic [CNT_W-1:0]   tok_count;
  logic               busy;

  int n_cmp = 0;
  int n_bad = 0;

  fanout_fork_ctrl #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .tok_count(tok_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks happen mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    // Reset then idle
    repeat (2) step();
    rst_n = 1'b1;
    settle();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_tok_count", tok_count, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    step();

    // Full-width burst, data 1..10 back-to-back
    cfg_en = 6'b111111;
    out_ready = 6'b111111;
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1'b1;
      in_data = DATA_W'(k);
      settle();
      check("burst_in_ready", in_ready, 1);
      if (k > 1) begin
        check("burst_data", out_data, k - 1);
        check("burst_valid", out_valid, 6'b111111);
      end
      step();
    end
    in_valid = 1'b0;
    settle();
    check("burst_last_data", out_data, 10);
    check("burst_last_valid", out_valid, 6'b111111);
    step();
    settle();
    check("burst_count", tok_count, 10);
    check("burst_idle_valid", out_valid, 0);
    step();

    // Ports 0 and 2 enabled, port 2 stalled
    cfg_en = 6'b000101;
    out_ready = 6'b000001;
    in_valid = 1'b1;
    in_data = 17'h55;
    step();
    in_valid = 1'b0;
    settle();
    check("stall_valid_c1", out_valid, 6'b000101);
    check("stall_in_ready_c1", in_ready, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_valid_hold", out_valid, 6'b000100);
      check("stall_in_ready_hold", in_ready, 0);
      step();
    end
    out_ready = 6'b000101;
    settle();
    check("stall_release_ready", in_ready, 1);
    check("stall_release_valid", out_valid, 6'b000100);
    step();
    settle();
    check("stall_done_valid", out_valid, 0);
    check("stall_count", tok_count, 11);
    step();

    // Mask change while FULL only affects the next token
    cfg_en = 6'b000011;
    out_ready = 6'b000000;
    in_valid = 1'b1;
    in_data = 17'hAA;
    step();
    in_valid = 1'b0;
    cfg_en = 6'b111100;
    settle();
    check("mask_held_valid", out_valid, 6'b000011);
    check("mask_held_data", out_data, 17'hAA);
    step();
    out_ready = 6'b111111;
    in_valid = 1'b1;
    in_data = 17'hBB;
    settle();
    check("mask_done_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    settle();
    check("mask_next_valid", out_valid, 6'b111100);
    check("mask_next_data", out_data, 17'hBB);
    check("mask_count_a", tok_count, 12);
    step();
    settle();
    check("mask_count_b", tok_count, 13);
    check("mask_idle_valid", out_valid, 0);
    step();

    // Zero mask swallows the token
    cfg_en = 6'b000000;
    out_ready = 6'b000000;
    in_valid = 1'b1;
    in_data = 17'h1F;
    settle();
    check("zero_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    settle();
    check("zero_valid", out_valid, 0);
    check("zero_busy", busy, 0);
    check("zero_count", tok_count, 13);
    step();

    // Flush with ports 0,1 pending and port 2 already sent
    cfg_en = 6'b000111;
    out_ready = 6'b000100;
    in_valid = 1'b1;
    in_data = 17'h33;
    step();
    in_valid = 1'b0;
    settle();
    check("flush_pre_valid", out_valid, 6'b000111);
    step();
    out_ready = 6'b000000;
    settle();
    check("flush_pending_valid", out_valid, 6'b000011);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 17'h44;
    settle();
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    settle();
    check("flush_busy", busy, 0);
    check("flush_valid", out_valid, 0);
    check("flush_count", tok_count, 13);
    check("flush_in_ready_after", in_ready, 1);
    step();

    // Asynchronous reset while FULL
    cfg_en = 6'b111111;
    out_ready = 6'b000000;
    in_valid = 1'b1;
    in_data = 17'h77;
    step();
    in_valid = 1'b0;
    settle();
    check("areset_pre_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("areset_busy", busy, 0);
    check("areset_valid", out_valid, 0);
    check("areset_data", out_data, 0);
    check("areset_count", tok_count, 0);
    check("areset_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    step();

    // Counter wrap: 17 tokens into a 4-bit counter
    cfg_en = 6'b111111;
    out_ready = 6'b111111;
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1;
      in_data = DATA_W'(k + 100);
      step();
    end
    in_valid = 1'b0;
    step();
    settle();
    check("wrap_count", tok_count, 1);
    check("wrap_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fanout_fork_ctrl.md
# fanout_fork_ctrl

Sequential eager-fork controller for one producer stream broadcast to up to NUM_OUT consumer streams in the sparse-stream fabric. It holds one token and presents it to every enabled consumer. Each consumer's acceptance is tracked independently, so a slow consumer does not block the handshakes of the others. Upstream ready is released only after all enabled consumers have taken the token. This replaces the purely combinational AND-of-readies fanout gating with a one-entry buffered fork.

## Interface
Parameters:
- NUM_OUT, 6, number of consumer ports
- DATA_W, 17, token width (data plus stream control bit)
- CNT_W, 16, width of the delivered-token counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- cfg_en  in  NUM_OUT  consumer enable mask, sampled only at token capture
- flush  in  1  synchronous clear of held token and sent flags
- in_valid  in  1  producer token valid
- in_data  in  DATA_W  producer token
- in_ready  out  1  controller can accept a token this cycle
- out_valid  out  NUM_OUT  per-consumer token valid
- out_data  out  DATA_W  held token, common to all consumers
- out_ready  in  NUM_OUT  per-consumer ready
- tok_count  out  CNT_W  number of tokens fully delivered, wraps modulo 2^CNT_W
- busy  out  1  a token is held (state FULL)

## Operation
- Two states: EMPTY and FULL. Registers: data_q, en_q[NUM_OUT], sent_q[NUM_OUT], count_q.
- EMPTY: in_ready=1, out_valid=0. On in_valid:
  - if cfg_en!=0: capture in_data into data_q and cfg_en into en_q, clear sent_q, go to FULL.
  - if cfg_en==0: token is accepted and discarded; stay EMPTY; count unchanged.
- FULL:
  - out_valid[i] = en_q[i] & ~sent_q[i]; out_data = data_q.
  - Handshake on port i: out_valid[i] & out_ready[i]. It sets sent_q[i].
  - done = AND over i of (~en_q[i] | sent_q[i] | out_ready[i]), i.e. every enabled port has completed its handshake, either earlier or in this cycle.
  - in_ready = done.
  - If done:
    - count_q increments.
    - If in_valid is also high, the next token is captured in the same cycle (back-to-back) using the new cfg_en, with the same zero-mask rule as EMPTY. A zero mask goes to EMPTY.
    - Otherwise go to EMPTY and clear sent_q.
- cfg_en changes while FULL have no effect on the held token.
- flush: highest priority below reset. Next state is EMPTY, sent_q=0, count unchanged. While flush=1: in_ready=0 and out_valid=0, so a token offered that cycle is not taken.
- out_ready[i] for a disabled or already-sent port is ignored.
- Counter wraps from 2^CNT_W-1 to 0 with no flag.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - state EMPTY, sent_q=0, en_q=0, data_q=0, count_q=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, tok_count=0, busy=0.
- Capture to first out_valid: 1 cycle (registered).
- Minimum occupancy is 1 cycle per token when all enabled consumers are ready. Sustained throughput is 1 token/cycle via same-cycle reload.
- in_ready is combinational from out_ready, state and flush. out_valid, out_data and busy are purely registered.
- tok_count updates the cycle after the completing handshake.
- A port's out_valid deasserts the cycle after its handshake. Other ports keep valid until their own handshakes.

## Test plan
- Reset then idle:
  - out_valid=0, in_ready=1, tok_count=0.
  - Drop rst_n mid-FULL: all outputs return to reset values immediately, without waiting for a clk edge.
- cfg_en=6'b111111, all out_ready=1, in_valid held 1 with data 1..10 -> each port sees 1..10 in order, one per cycle, and tok_count reaches 10.
- cfg_en=6'b000101, out_ready[0]=1, out_ready[2] stalled 4 cycles:
  - port 0 handshakes in cycle 1 and then drops valid.
  - port 2 holds valid until its ready.
  - in_ready=0 until port 2 accepts.
  - ports 1 and 3-5 never assert valid.
- Mask change mid-token: capture with cfg_en=6'b000011, switch to 6'b111100 while FULL -> only ports 0 and 1 receive the held token; the next token goes to ports 2-5.
- cfg_en=0 with in_valid=1 -> token accepted (in_ready=1), no out_valid, tok_count unchanged, state stays EMPTY.
- flush with ports 0 and 1 pending and port 2 already sent -> next cycle EMPTY, no out_valid, tok_count unchanged, in_ready=1 once flush drops. Counter wrap check with CNT_W=4: 17 tokens -> tok_count=1.
